int_arb: RTL

Interrupt arbiter for the PDP-11 iopage peripherals. Collects the `interrupt`/`vector` pairs driven by device register blocks (line clock, console, disk, etc.) and selects the highest-priority request that exceeds the CPU's current processor priority. Presents that request and its vector to the CPU, then returns a one-cycle acknowledge to the granting device so the device can clear its request. It sits between the device register blocks and the CPU trap/interrupt sequencer.

---
 rtl/pdp11_int_pkg.sv | 25 ++
 rtl/int_prio_enc.sv | 30 +++
 rtl/int_arb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pdp11_int_pkg.sv
// Shared definitions for the PDP-11 interrupt arbiter: widths, BR levels, FSM states.
package pdp11_int_pkg;

    localparam int VEC_W = 8;
    localparam int IPL_W = 3;

    // Processor priority level that each bus-request line maps to
    localparam logic [IPL_W-1:0] LVL_BR4 = 3'd4;
    localparam logic [IPL_W-1:0] LVL_BR5 = 3'd5;
    localparam logic [IPL_W-1:0] LVL_BR6 = 3'd6;
    localparam logic [IPL_W-1:0] LVL_BR7 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_GRANT,
        ST_HOLDOFF
    } arb_state_t;

    // 2-bit BR code (0..3) to interrupt level (4..7)
    function automatic logic [IPL_W-1:0] br_to_lvl(input logic [1:0] br);
        return LVL_BR4 + {1'b0, br};
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational priority encoder: highest level wins, lowest index breaks ties.
module int_prio_enc
    import pdp11_int_pkg::*;
#(
    parameter  int NSRC  = 8,
    localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0]       i_elig,
    input  logic [NSRC*IPL_W-1:0] i_lvl,
    output logic [IDX_W-1:0]      o_idx,
    output logic [IPL_W-1:0]      o_lvl,
    output logic                  o_any
);

    // Scan from the highest index down; ">=" lets a lower index take over an equal level
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_idx = '0;
        o_lvl = '0;
        o_any = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (i_elig[i] && (!o_any || (i_lvl[i*IPL_W +: IPL_W] >= o_lvl))) begin
                o_any = 1'b1;
                o_lvl = i_lvl[i*IPL_W +: IPL_W];
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_arb.sv
// Interrupt arbiter: offers the best eligible device request to the CPU and acks the device.
module int_arb
    import pdp11_int_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NSRC-1:0]       dev_int,
    input  logic [VEC_W*NSRC-1:0] dev_vec,
    input  logic [2*NSRC-1:0]     dev_br,
    input  logic [IPL_W-1:0]      cpu_ipl,
    input  logic                  cpu_int_ack,
    output logic                  cpu_int_req,
    output logic [VEC_W-1:0]      cpu_int_vector,
    output logic [IPL_W-1:0]      cpu_int_ipl,
    output logic [NSRC-1:0]       dev_int_ack,
    output logic                  stray_ack
);

    localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    arb_state_t            r_state;
    logic [IDX_W-1:0]      r_win;
    logic [VEC_W-1:0]      r_vec;
    logic [IPL_W-1:0]      r_ipl;
    logic                  r_req;
    logic [NSRC-1:0]       r_dev_ack;
    logic                  r_stray;

    logic [NSRC*IPL_W-1:0] w_lvl;
    logic [NSRC-1:0]       w_elig;
    logic [IDX_W-1:0]      w_enc_idx;
    logic [IPL_W-1:0]      w_enc_lvl;
    logic                  w_enc_any;
    logic [VEC_W-1:0]      w_enc_vec;
    logic                  w_win_still;
    logic                  w_preempt;

    // Per-device level and eligibility; the just-granted device is masked during HOLDOFF
    always_comb begin
        w_lvl  = '0;
        w_elig = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_lvl[i*IPL_W +: IPL_W] = br_to_lvl(dev_br[2*i +: 2]);
            w_elig[i] = dev_int[i]
                     && (w_lvl[i*IPL_W +: IPL_W] > cpu_ipl)
                     && !((r_state == ST_HOLDOFF) && (r_win == IDX_W'(i)));
        end
    end

    int_prio_enc #(
        .NSRC (NSRC)
    ) u_prio_enc (
        .i_elig (w_elig),
        .i_lvl  (w_lvl),
        .o_idx  (w_enc_idx),
        .o_lvl  (w_enc_lvl),
        .o_any  (w_enc_any)
    );

    // Vector of the current arbitration winner, muxed without a variable-width part-select
    always_comb begin
        w_enc_vec = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_enc_idx == IDX_W'(i)) begin
                w_enc_vec = dev_vec[i*VEC_W +: VEC_W];
            end
        end
    end

    assign w_win_still = w_elig[r_win];
    assign w_preempt   = w_enc_any && (w_enc_lvl > r_ipl);

    // Arbitration FSM with registered CPU-side and device-side outputs
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_win     <= '0;
            r_vec     <= '0;
            r_ipl     <= '0;
            r_req     <= 1'b0;
            r_dev_ack <= '0;
            r_stray   <= 1'b0;
        end else begin
            r_dev_ack <= '0;
            if (cpu_int_ack && (r_state != ST_OFFER)) begin
                r_stray <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_enc_any) begin
                        r_win   <= w_enc_idx;
                        r_vec   <= w_enc_vec & 8'hFC;
                        r_ipl   <= w_enc_lvl;
                        r_req   <= 1'b1;
                        r_state <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (cpu_int_ack) begin
                        r_req     <= 1'b0;
                        r_dev_ack <= {{(NSRC-1){1'b0}}, 1'b1} << r_win;
                        r_state   <= ST_GRANT;
                    end else if (!w_win_still || w_preempt) begin
                        r_req   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT:   r_state <= ST_HOLDOFF;
                ST_HOLDOFF: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_int_req    = r_req;
    assign cpu_int_vector = r_vec;
    assign cpu_int_ipl    = r_ipl;
    assign dev_int_ack    = r_dev_ack;
    assign stray_ack      = r_stray;

endmodule
